// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: issues word-aligned fetches, tracks in-order responses,
// buffers returned words with their PC, and flushes buffered/in-flight work on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CntW:0]   DepthCap = (CntW + 1)'(DEPTH);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]     fifo_pc_q   [DEPTH];
  logic [31:0]     fifo_data_q [DEPTH];

  logic            req_fire;
  logic            push;
  logic            pop;
  logic [CntW:0]   in_use;
  logic [31:0]     redirect_target;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrOne;
  endfunction

  // Credits cover both in-flight requests and buffered words so a push can never overflow.
  assign in_use          = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid  = !rst && !redirect_valid && (in_use < DepthCap);
  assign imem_req_addr   = fetch_pc_q;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  assign push       = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign inst       = fifo_data_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    unique case ({req_fire, imem_resp_valid})
      2'b10:   outstanding_d = outstanding_q + CntOne;
      2'b01:   outstanding_d = outstanding_q - CntOne;
      default: outstanding_d = outstanding_q;
    endcase

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      // A response landing this cycle is already discarded, so it needs no drop credit.
      drop_cnt_d = outstanding_q - CntW'(imem_resp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (imem_resp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CntOne;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) begin
        fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
        fifo_data_q[wr_ptr_q] <= imem_resp_data;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count_q == DepthCnt) && !pop))
        else $error("fetch_unit: response pushed into a full instruction buffer");
      assert (!(imem_resp_valid && (outstanding_q == '0)))
        else $error("fetch_unit: response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-configurable memory model answers fetches,
// the stimulus queues hand-computed PCs and a monitor checks every consumed instruction.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int unsigned DEPTH  = 2;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(
    .RESET_PC(RST_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  logic [31:0] exp_q[$];

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Memory model: in-order responses, per-request latency, optional random backpressure.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  int          lat        = 1;
  bit          rand_ready = 1'b0;
  int          mdl_out    = 0;
  int          last_due   = 0;
  logic [31:0] exp_req_addr;
  logic        prev_stall;
  logic [31:0] prev_addr;

  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    prev_stall      = 1'b0;
    prev_addr       = '0;
    exp_req_addr    = RST_PC;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pend_q.delete();
        mdl_out         = 0;
        last_due        = 0;
        exp_req_addr    = RST_PC;
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
        prev_stall      = 1'b0;
      end else begin
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(pend_q[0].addr);
          void'(pend_q.pop_front());
          mdl_out--;
        end else begin
          imem_resp_valid = 1'b0;
          imem_resp_data  = '0;
        end
        imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (redirect_valid) begin
          exp_req_addr = {redirect_pc[31:2], 2'b00};
        end else if (prev_stall) begin
          check("req_hold_valid", 32'(imem_req_valid), 32'd1);
          check("req_hold_addr", imem_req_addr, prev_addr);
        end
        if (imem_req_valid && imem_req_ready) begin
          int due;
          check("req_addr", imem_req_addr, exp_req_addr);
          exp_req_addr = exp_req_addr + 32'd4;
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend_q.push_back('{addr: imem_req_addr, due: due});
          mdl_out++;
          check("in_flight_cap", 32'(mdl_out <= DEPTH), 32'd1);
        end
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_req_addr;
      end
    end
  end

  // Monitor: every consumed instruction must be the next expected PC with its memory word.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_inst: got pc %h, expected no delivery (cycle %0d)",
                   inst_pc, cyc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst_data", inst, mem_word(e));
        end
      end
    end
  end

  // Leaves with inst_ready low at a falling edge, before the monitor samples.
  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (exp_q.size() != 0 && n < budget);
    inst_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d entries left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);

    // Sequential fetch from RESET_PC, first word visible two cycles after reset release
    push_seq(RST_PC, 8);
    @(negedge clk);
    rst        = 1'b0;
    inst_ready = 1'b1;
    #3;
    check("a_inst_valid", 32'(inst_valid), 32'd0);
    check("a_req_valid", 32'(imem_req_valid), 32'd1);
    check("a_req_addr", imem_req_addr, 32'h100);
    @(negedge clk);
    #3;
    check("b_inst_valid", 32'(inst_valid), 32'd0);
    check("b_req_addr", imem_req_addr, 32'h104);
    @(negedge clk);
    #3;
    check("c_inst_valid", 32'(inst_valid), 32'd1);
    check("c_inst_pc", inst_pc, 32'h100);
    wait_drain(100, "seq");

    // Decoder stall: buffer fills, requests stop, then drains in order
    repeat (10) @(negedge clk);
    #3;
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_inst_valid", 32'(inst_valid), 32'd1);
    check("stall_head_pc", inst_pc, 32'h120);
    check("stall_head_data", inst, mem_word(32'h120));
    push_seq(32'h120, 8);
    @(negedge clk);
    inst_ready = 1'b1;
    wait_drain(100, "stall");

    // Redirect with one request in flight and one word buffered (3-cycle memory)
    lat = 3;
    repeat (12) @(negedge clk);
    push_seq(32'h140, 1);
    @(negedge clk);
    inst_ready = 1'b1;
    #3;
    check("p3_full_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    inst_ready = 1'b0;
    #3;
    check("p3_req_valid", 32'(imem_req_valid), 32'd1);
    check("p3_req_addr", imem_req_addr, 32'h148);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2002;
    exp_q.delete();
    push_seq(32'h2000, 8);
    #3;
    check("p3_redir_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    #3;
    check("p3_flush_valid", 32'(inst_valid), 32'd0);
    wait_drain(100, "redir");

    // Redirect in the same cycle a response arrives (1-cycle memory)
    lat = 1;
    repeat (12) @(negedge clk);
    push_seq(32'h2020, 1);
    @(negedge clk);
    inst_ready = 1'b1;
    #3;
    check("p4_full_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    inst_ready = 1'b0;
    #3;
    check("p4_req_addr", imem_req_addr, 32'h2028);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    exp_q.delete();
    push_seq(32'h3000, 8);
    #3;
    check("p4_resp_same_cycle", 32'(imem_resp_valid), 32'd1);
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    wait_drain(100, "redir_resp");

    // Random request backpressure with 3-cycle memory
    rand_ready = 1'b1;
    lat        = 3;
    push_seq(32'h3020, 16);
    @(negedge clk);
    inst_ready = 1'b1;
    wait_drain(400, "rand");

    // Address wrap at the top of the address space
    repeat (3) @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF6;
    exp_q.delete();
    push_seq(32'hFFFF_FFF4, 6);
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    wait_drain(200, "wrap");

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
